linescanner_frame_controller: RTL and testbench

Frame-level sequencer for the line-scan sensor capture path. It arms the capture unit's `enable` and enforces a minimum line period, counts lines per frame and pixels per line from `lval`, and reports frame boundaries and timing faults. It sits between the host/register interface and `linescanner_image_capture_unit`, clocked by the same pixel clock.

---
 rtl/linescanner_frame_controller.sv | 218 +++++++++++++++++++++
 tb/tb_linescanner_frame_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/linescanner_frame_controller.sv
// Frame sequencer for the line-scan capture path: arms capture, enforces line period, flags faults.
// Optional build macro LINESCANNER_LINE_CHECK_EN enables the per-line pixel-length check.
module linescanner_frame_controller #(
  parameter int unsigned PIXELS_PER_LINE = 1024,
  parameter int unsigned ARM_TIMEOUT     = 4095
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [11:0] lines_per_frame,
  input  logic [15:0] line_period,
  input  logic        lval,
  output logic        capture_enable,
  output logic        busy,
  output logic        frame_start,
  output logic        frame_done,
  output logic        aborted,
  output logic [11:0] line_index,
  output logic [10:0] pixel_count,
  output logic        line_length_error,
  output logic        overrun,
  output logic        timeout
);

  if (PIXELS_PER_LINE == 0 || PIXELS_PER_LINE > 2047) begin : g_bad_pixels_per_line
    $error("PIXELS_PER_LINE must fit the 11-bit pixel counter");
  end
  if (ARM_TIMEOUT == 0 || ARM_TIMEOUT > 4095) begin : g_bad_arm_timeout
    $error("ARM_TIMEOUT must fit the 12-bit arm counter");
  end

  localparam logic [11:0] ARM_LAST = 12'(ARM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LINE,
    GAP,
    DONE
  } state_t;

  state_t      state;
  logic        lval_d;
  logic        lval_rise;
  logic        lval_fall;
  logic        accept_start;
  logic        line_end;
  logic        stop_seen;
  logic [11:0] cfg_lines;
  logic [15:0] cfg_period;
  logic [11:0] arm_cnt;
  logic [15:0] period_cnt;
  logic [10:0] pix_cnt;
  logic        frame_started;
  logic        stop_pending;

  assign lval_rise    = lval & ~lval_d;
  assign lval_fall    = ~lval & lval_d;
  assign accept_start = (state == IDLE) & start & ~stop & (lines_per_frame != '0);
  assign line_end     = (state == LINE) & lval_fall;
  // A stop landing on the very cycle a gap expires still counts as pending.
  assign stop_seen    = stop_pending | stop;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state          <= IDLE;
      lval_d         <= 1'b0;
      cfg_lines      <= '0;
      cfg_period     <= '0;
      arm_cnt        <= '0;
      period_cnt     <= '0;
      pix_cnt        <= '0;
      frame_started  <= 1'b0;
      stop_pending   <= 1'b0;
      capture_enable <= 1'b0;
      busy           <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      aborted        <= 1'b0;
      line_index     <= '0;
      pixel_count    <= '0;
      overrun        <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      lval_d      <= lval;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      aborted     <= 1'b0;

      if (lval_rise && (state == GAP || state == DONE)) begin
        overrun <= 1'b1;
      end

      if ((state == LINE || state == GAP) && period_cnt != '1) begin
        period_cnt <= period_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (accept_start) begin
            cfg_lines      <= lines_per_frame;
            cfg_period     <= line_period;
            line_index     <= '0;
            overrun        <= 1'b0;
            timeout        <= 1'b0;
            frame_started  <= 1'b0;
            stop_pending   <= 1'b0;
            arm_cnt        <= '0;
            capture_enable <= 1'b1;
            busy           <= 1'b1;
            state          <= ARM;
          end
        end

        ARM: begin
          if (arm_cnt != '1) begin
            arm_cnt <= arm_cnt + 12'd1;
          end
          if (stop) begin
            aborted        <= 1'b1;
            capture_enable <= 1'b0;
            busy           <= 1'b0;
            stop_pending   <= 1'b0;
            state          <= IDLE;
          end else if (lval_rise) begin
            period_cnt    <= 16'd1;
            pix_cnt       <= 11'd1;
            frame_start   <= ~frame_started;
            frame_started <= 1'b1;
            state         <= LINE;
          end else if (arm_cnt == ARM_LAST) begin
            timeout        <= 1'b1;
            aborted        <= 1'b1;
            capture_enable <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end

        LINE: begin
          if (stop) begin
            stop_pending <= 1'b1;
          end
          if (line_end) begin
            pixel_count    <= pix_cnt;
            line_index     <= line_index + 12'd1;
            capture_enable <= 1'b0;
            state          <= GAP;
          end else if (lval && pix_cnt != '1) begin
            pix_cnt <= pix_cnt + 11'd1;
          end
        end

        GAP: begin
          if (stop) begin
            stop_pending <= 1'b1;
          end
          if (period_cnt >= cfg_period) begin
            if (line_index == cfg_lines) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else if (stop_seen) begin
              aborted      <= 1'b1;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
              state        <= IDLE;
            end else begin
              arm_cnt        <= '0;
              capture_enable <= 1'b1;
              state          <= ARM;
            end
          end
        end

        DONE: begin
          if (continuous && !stop_seen) begin
            line_index     <= '0;
            frame_started  <= 1'b0;
            arm_cnt        <= '0;
            capture_enable <= 1'b1;
            state          <= ARM;
          end else begin
            busy         <= 1'b0;
            stop_pending <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          capture_enable <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

`ifdef LINESCANNER_LINE_CHECK_EN
  logic len_err_q;

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      len_err_q <= 1'b0;
    end else if (accept_start) begin
      len_err_q <= 1'b0;
    end else if (line_end && pix_cnt != 11'(PIXELS_PER_LINE)) begin
      len_err_q <= 1'b1;
    end
  end

  assign line_length_error = len_err_q;
`else
  assign line_length_error = 1'b0;
`endif

endmodule

// File: tb/tb_linescanner_frame_controller.sv
// Directed bench for linescanner_frame_controller; expectations are hand-derived cycle counts.
module tb_linescanner_frame_controller;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [11:0] lines_per_frame = '0;
  logic [15:0] line_period = '0;
  logic        lval = 1'b0;
  logic        capture_enable;
  logic        busy;
  logic        frame_start;
  logic        frame_done;
  logic        aborted;
  logic [11:0] line_index;
  logic [10:0] pixel_count;
  logic        line_length_error;
  logic        overrun;
  logic        timeout;

  linescanner_frame_controller #(
    .PIXELS_PER_LINE(1024),
    .ARM_TIMEOUT    (4095)
  ) dut (
    .pixel_clock      (pixel_clock),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .continuous       (continuous),
    .lines_per_frame  (lines_per_frame),
    .line_period      (line_period),
    .lval             (lval),
    .capture_enable   (capture_enable),
    .busy             (busy),
    .frame_start      (frame_start),
    .frame_done       (frame_done),
    .aborted          (aborted),
    .line_index       (line_index),
    .pixel_count      (pixel_count),
    .line_length_error(line_length_error),
    .overrun          (overrun),
    .timeout          (timeout)
  );

  always #5 pixel_clock = ~pixel_clock;

`ifdef LINESCANNER_LINE_CHECK_EN
  localparam logic LEN_ERR_EXP = 1'b1;
`else
  localparam logic LEN_ERR_EXP = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int fs_n     = 0;
  int fd_n     = 0;
  int ab_n     = 0;
  int fs_cyc   = -1;
  int rise_cyc = 0;
  int prev_rise = 0;

  always @(posedge pixel_clock) cyc <= cyc + 1;

  // Pulse counters sampled mid-cycle, so each one-cycle pulse is seen exactly once.
  always @(negedge pixel_clock) begin
    if (frame_start) begin
      fs_n   = fs_n + 1;
      fs_cyc = cyc;
    end
    if (frame_done) fd_n = fd_n + 1;
    if (aborted)    ab_n = ab_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic do_start(input logic [11:0] lines, input logic [15:0] period, input logic cont);
    lines_per_frame = lines;
    line_period     = period;
    continuous      = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for arming, idles delay clocks, then holds lval for len clocks; returns just after the fall edge.
  task automatic run_line(input int len, input int delay, input int stop_at);
    int n = 0;
    while (!capture_enable && n < 5000) begin
      tick();
      n++;
    end
    check("arm_wait", 32'(capture_enable), 32'd1);
    repeat (delay) tick();
    lval      = 1'b1;
    prev_rise = rise_cyc;
    rise_cyc  = cyc + 1;
    for (int i = 0; i < len; i++) begin
      stop = (i == stop_at);
      tick();
    end
    stop = 1'b0;
    lval = 1'b0;
    tick();
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(frame_done || aborted) && n < budget) begin
      tick();
      n++;
    end
    check("end_wait", 32'(frame_done | aborted), 32'd1);
  endtask

  int fs0, fd0, ab0, n;

  initial begin
    repeat (3) tick();
    check("rst_outputs", {capture_enable, busy, frame_start, frame_done, aborted,
                          line_index, pixel_count, line_length_error, overrun, timeout}, '0);
    reset = 1'b0;
    tick();

    // Starts that must be ignored, and an lval pulse while idle that is not an overrun
    do_start(12'd0, 16'd1100, 1'b0);
    check("start_zero_lines", 32'(busy), 32'd0);
    stop = 1'b1;
    do_start(12'd3, 16'd1100, 1'b0);
    stop = 1'b0;
    check("start_with_stop", 32'(busy), 32'd0);
    lval = 1'b1;
    repeat (3) tick();
    lval = 1'b0;
    repeat (2) tick();
    check("idle_rise_no_overrun", 32'(overrun), 32'd0);

    // Nominal three-line frame
    fs0 = fs_n; fd0 = fd_n;
    do_start(12'd3, 16'd1100, 1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    run_line(1024, 10, -1);
    check("fs_latency", 32'(fs_cyc), 32'(rise_cyc));
    check("line1_index", 32'(line_index), 32'd1);
    run_line(1024, 10, -1);
    check("line2_spacing", 32'(rise_cyc - prev_rise), 32'd1111);
    run_line(1024, 10, -1);
    check("line3_spacing", 32'(rise_cyc - prev_rise), 32'd1111);
    wait_end(1500);
    check("done_pulse", 32'(frame_done), 32'd1);
    check("done_latency", 32'(cyc - rise_cyc), 32'd1100);
    repeat (2) tick();
    check("frame_start_count", 32'(fs_n - fs0), 32'd1);
    check("frame_done_count", 32'(fd_n - fd0), 32'd1);
    check("final_index", 32'(line_index), 32'd3);
    check("final_pixels", 32'(pixel_count), 32'd1024);
    check("flags_clean", {29'd0, line_length_error, overrun, timeout}, 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);

    // Short second line
    do_start(12'd3, 16'd1100, 1'b0);
    run_line(1024, 10, -1);
    run_line(1000, 10, -1);
    check("short_pixels", 32'(pixel_count), 32'd1000);
    check("short_len_err", 32'(line_length_error), 32'(LEN_ERR_EXP));
    run_line(1024, 10, -1);
    check("short_next_spacing", 32'(rise_cyc - prev_rise), 32'd1111);
    wait_end(1500);
    tick();
    check("short_final_pixels", 32'(pixel_count), 32'd1024);
    check("short_len_err_sticky", 32'(line_length_error), 32'(LEN_ERR_EXP));

    // Arm timeout: lval never rises
    fd0 = fd_n;
    do_start(12'd1, 16'd100, 1'b0);
    check("len_err_cleared", 32'(line_length_error), 32'd0);
    n = 0;
    while (!aborted && n < 5000) begin
      tick();
      n++;
    end
    check("timeout_latency", 32'(n), 32'd4095);
    check("timeout_flag", 32'(timeout), 32'd1);
    check("timeout_idle", {30'd0, busy, capture_enable}, 32'd0);
    tick();
    check("timeout_no_done", 32'(fd_n - fd0), 32'd0);

    // Overrun pulse inside a gap
    fd0 = fd_n;
    do_start(12'd2, 16'd1100, 1'b0);
    check("timeout_cleared", 32'(timeout), 32'd0);
    run_line(1024, 10, -1);
    repeat (20) tick();
    lval = 1'b1;
    repeat (3) tick();
    lval = 1'b0;
    check("overrun_flag", 32'(overrun), 32'd1);
    run_line(1024, 10, -1);
    wait_end(1500);
    check("overrun_done", 32'(frame_done), 32'd1);
    tick();
    check("overrun_index", 32'(line_index), 32'd2);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Stop during line 1 of 4
    fd0 = fd_n; ab0 = ab_n;
    do_start(12'd4, 16'd1100, 1'b0);
    run_line(1024, 10, 500);
    check("stop_line_completes", 32'(line_index), 32'd1);
    wait_end(1500);
    check("stop_aborted", 32'(aborted), 32'd1);
    check("stop_after_gap", 32'(cyc - rise_cyc), 32'd1100);
    tick();
    check("stop_idle", 32'(busy), 32'd0);
    check("stop_no_done", 32'(fd_n - fd0), 32'd0);
    check("stop_abort_count", 32'(ab_n - ab0), 32'd1);

    // Continuous two-line frames, then reset mid-line
    fd0 = fd_n; fs0 = fs_n; ab0 = ab_n;
    do_start(12'd2, 16'd1100, 1'b1);
    run_line(1024, 10, -1);
    run_line(1024, 10, -1);
    wait_end(1500);
    check("cont_done1", 32'(frame_done), 32'd1);
    tick();
    check("cont_rearm", {29'd0, busy, capture_enable, 1'b0}, 32'd6);
    check("cont_index_cleared", 32'(line_index), 32'd0);
    run_line(1024, 10, -1);
    run_line(1024, 10, -1);
    wait_end(1500);
    check("cont_done2", 32'(frame_done), 32'd1);
    tick();
    check("cont_done_count", 32'(fd_n - fd0), 32'd2);
    check("cont_start_count", 32'(fs_n - fs0), 32'd2);
    check("cont_still_busy", 32'(busy), 32'd1);
    continuous = 1'b0;
    repeat (10) tick();
    lval = 1'b1;
    repeat (100) tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("midline_reset_outputs", {capture_enable, busy, frame_start, frame_done, aborted,
                                    line_index, pixel_count, line_length_error, overrun, timeout}, '0);
    reset = 1'b0;
    lval  = 1'b0;
    repeat (5) tick();
    check("reset_no_abort", 32'(ab_n - ab0), 32'd0);
    check("reset_stays_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
